mem_stage: RTL and testbench

Memory stage of the five-stage ARM pipeline. It sits between the EXE/MEM pipeline register (`EXE_reg`) and the MEM/WB pipeline register (`MEM_REG`). It services `MEM_R`/`MEM_W` requests against an internal word-addressed data memory with a fixed multi-cycle access latency. While an access is in progress it drives `ready` low so that the hazard/freeze logic stalls the upstream stages. All other fields pass through to `MEM_REG`.

---
 rtl/mem_stage_if.sv | 27 ++
 rtl/mem_stage.sv | 83 ++++++++
 tb/tb_mem_stage.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Bus between the EXE/MEM register, the memory stage and the MEM/WB register.
// The master is the pipeline side; the slave is mem_stage.
interface mem_stage_if;
  logic        WB_EN;
  logic        MEM_R;
  logic        MEM_W;
  logic [31:0] ALU_res;
  logic [31:0] val_rm;
  logic [3:0]  dest;

  logic        WB_EN_out;
  logic        MEM_R_out;
  logic [31:0] ALU_res_out;
  logic [3:0]  dest_out;
  logic [31:0] data_mem;
  logic        ready;

  modport master (
    output WB_EN, MEM_R, MEM_W, ALU_res, val_rm, dest,
    input  WB_EN_out, MEM_R_out, ALU_res_out, dest_out, data_mem, ready
  );

  modport slave (
    input  WB_EN, MEM_R, MEM_W, ALU_res, val_rm, dest,
    output WB_EN_out, MEM_R_out, ALU_res_out, dest_out, data_mem, ready
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: multi-cycle word-addressed data memory behind an
// IDLE/ACCESS/DONE FSM whose ready output freezes the upstream stages.
module mem_stage #(
  parameter int DEPTH   = 64,
  parameter int BASE    = 1024,
  parameter int LATENCY = 4
) (
  input logic        clk,
  input logic        rst,
  mem_stage_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   data_q;
  logic [31:0]   mem [DEPTH];

  logic          req;
  logic          fire;
  logic          ready;
  logic [AW-1:0] idx;

  assign req  = bus.MEM_R | bus.MEM_W;
  assign fire = (state == ACCESS) && (cnt == '0);
  // Byte offset bits drop out in the shift; truncation gives the silent wrap.
  assign idx  = AW'((bus.ALU_res - 32'(BASE)) >> 2);

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    ready = 1'b1;
    case (state)
      IDLE:    ready = ~req;
      ACCESS:  ready = 1'b0;
      default: ready = 1'b1;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order across blocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state <= ACCESS;
            cnt   <= CW'(LATENCY - 1);
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= DONE;
            if (bus.MEM_R) data_q <= mem[idx];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the memory array has no reset; contents survive rst, and a reset
  // mid-access drops state to IDLE so fire cannot commit the pending write.
  always_ff @(posedge clk) begin
    if (fire && bus.MEM_W) mem[idx] <= bus.val_rm;
  end

  assign bus.ready       = ready;
  assign bus.WB_EN_out   = bus.WB_EN & ready;
  assign bus.MEM_R_out   = bus.MEM_R;
  assign bus.ALU_res_out = bus.ALU_res;
  assign bus.dest_out    = bus.dest;
  assign bus.data_mem    = data_q;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: one LATENCY=4 and one LATENCY=1 instance,
// load results checked through a scoreboard queue fed at issue time.
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_if bus_a ();
  mem_stage_if bus_b ();

  mem_stage #(.DEPTH(64), .BASE(1024), .LATENCY(4)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  mem_stage #(.DEPTH(64), .BASE(1024), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // sel picks which instance the tasks drive and observe
  bit          sel = 1'b0;
  logic        s_ready, s_wb, s_memr;
  logic [31:0] s_data, s_alu;
  logic [3:0]  s_dest;
  assign s_ready = sel ? bus_b.ready       : bus_a.ready;
  assign s_wb    = sel ? bus_b.WB_EN_out   : bus_a.WB_EN_out;
  assign s_memr  = sel ? bus_b.MEM_R_out   : bus_a.MEM_R_out;
  assign s_data  = sel ? bus_b.data_mem    : bus_a.data_mem;
  assign s_alu   = sel ? bus_b.ALU_res_out : bus_a.ALU_res_out;
  assign s_dest  = sel ? bus_b.dest_out    : bus_a.dest_out;

  logic [31:0] model     [2][64];
  bit          known     [2][64];
  logic [31:0] exp_data  [2];
  bit          exp_known [2];
  logic [31:0] sb_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - 32'd1024;
    return int'((off >> 2) % 32'd64);
  endfunction

  task automatic drive(input logic wb, input logic r, input logic w,
                       input logic [31:0] alu, input logic [31:0] rm, input logic [3:0] d);
    if (sel) begin
      bus_b.WB_EN = wb; bus_b.MEM_R = r; bus_b.MEM_W = w;
      bus_b.ALU_res = alu; bus_b.val_rm = rm; bus_b.dest = d;
    end else begin
      bus_a.WB_EN = wb; bus_a.MEM_R = r; bus_a.MEM_W = w;
      bus_a.ALU_res = alu; bus_a.val_rm = rm; bus_a.dest = d;
    end
  endtask

  // Entered with the request already on the bus in its first IDLE cycle;
  // returns just after the DONE edge with a no-op driven.
  task automatic wait_done(input bit is_read, input bit have_exp, input logic wb,
                           input logic [31:0] alu, input string tag);
    int lows = 0;
    bit done = 1'b0;
    int lat  = sel ? 1 : 4;
    logic [31:0] exp;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (s_ready === 1'b1) begin
        done = 1'b1;
        break;
      end
      lows++;
      check({tag, "_bubble"}, 32'(s_wb), 32'(1'b0));
    end
    check({tag, "_done"}, 32'(done), 32'(1'b1));
    check({tag, "_low_cycles"}, 32'(lows), 32'(lat + 1));
    check({tag, "_wb_out"}, 32'(s_wb), 32'(wb));
    check({tag, "_memr_out"}, 32'(s_memr), 32'(is_read));
    check({tag, "_alu_out"}, s_alu, alu);
    if (is_read) begin
      if (have_exp && sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        check({tag, "_data"}, s_data, exp);
        exp_data[sel]  = exp;
        exp_known[sel] = 1'b1;
      end else begin
        exp_known[sel] = 1'b0;
      end
    end else if (exp_known[sel]) begin
      check({tag, "_data_held"}, s_data, exp_data[sel]);
    end
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  task automatic issue(input logic r, input logic w, input logic [31:0] alu,
                       input logic [31:0] rm, input logic wb, input string tag);
    int  i = widx(alu);
    bit  have = 1'b0;
    drive(wb, r, w, alu, rm, 4'd3);
    if (w) begin
      model[sel][i] = rm;
      known[sel][i] = 1'b1;
    end
    if (r && known[sel][i]) begin
      sb_q.push_back(model[sel][i]);
      have = 1'b1;
    end
    wait_done(r, have, wb, alu, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      exp_known[s] = 1'b0;
      for (int i = 0; i < 64; i++) known[s][i] = 1'b0;
    end
    sel = 1'b1; drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    sel = 1'b0; drive(1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 4'd1);
    rst = 1'b0;

    // Reset held with a load request present
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data_a", bus_a.data_mem, 32'd0);
    check("rst_ready_a_req", 32'(bus_a.ready), 32'(1'b0));
    check("rst_wb_gated_a", 32'(bus_a.WB_EN_out), 32'(1'b0));
    check("rst_data_b", bus_b.data_mem, 32'd0);
    check("rst_ready_b_idle", 32'(bus_b.ready), 32'(1'b1));
    @(posedge clk);
    #1 rst = 1'b1;
    wait_done(1'b1, 1'b0, 1'b1, 32'd1024, "rst_release");

    // Store then load
    issue(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0, "st_1028");
    issue(1'b1, 1'b0, 32'd1028, 32'd0, 1'b1, "ld_1028");

    // Wrap and byte offset
    issue(1'b0, 1'b1, 32'd1280, 32'h12345678, 1'b0, "st_wrap");
    issue(1'b1, 1'b0, 32'd1024, 32'd0, 1'b1, "ld_1024");
    issue(1'b1, 1'b0, 32'd1027, 32'd0, 1'b1, "ld_1027");

    // Non-memory instruction
    drive(1'b1, 1'b0, 1'b0, 32'd7, 32'd0, 4'd5);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("nonmem_ready", 32'(s_ready), 32'(1'b1));
      check("nonmem_wb", 32'(s_wb), 32'(1'b1));
      check("nonmem_alu", s_alu, 32'd7);
      check("nonmem_dest", 32'(s_dest), 32'd5);
      check("nonmem_data", s_data, 32'h12345678);
    end
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

    // Reset during the second ACCESS cycle of a store
    issue(1'b0, 1'b1, 32'd1032, 32'h11111111, 1'b0, "st_prior");
    drive(1'b0, 1'b0, 1'b1, 32'd1032, 32'hAAAA5555, 4'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_data", s_data, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_data[0] = 32'd0; exp_known[0] = 1'b1;
    exp_data[1] = 32'd0; exp_known[1] = 1'b1;
    @(negedge clk);
    check("abort_ready_idle", 32'(s_ready), 32'(1'b1));
    @(posedge clk);
    #1;
    issue(1'b1, 1'b0, 32'd1032, 32'd0, 1'b1, "ld_after_abort");

    // Back-to-back accesses on the LATENCY=1 instance
    sel = 1'b1;
    issue(1'b0, 1'b1, 32'd1040, 32'hCAFEF00D, 1'b0, "l1_st_a");
    issue(1'b0, 1'b1, 32'd1044, 32'h0BADF00D, 1'b0, "l1_st_b");
    issue(1'b1, 1'b0, 32'd1040, 32'd0, 1'b1, "l1_ld_a");
    issue(1'b1, 1'b0, 32'd1044, 32'd0, 1'b1, "l1_ld_b");
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
